// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with centre sampling, optional parity,
// framing/overrun detection and a valid/ready output register.
module uart_rx_core #(
  parameter int unsigned DATA_BITS  = 7,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [2:0]           state_out
);

  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS);

  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 rx_meta;
  logic                 rxs;
  logic                 armed_q;
  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [SC_W-1:0]      sc_q;
  logic [SC_W-1:0]      sc_d;
  logic [BC_W-1:0]      bc_q;
  logic [BC_W-1:0]      bc_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_err_q;
  logic                 par_err_d;
  logic                 par_calc_c;
  logic                 done_c;
  logic                 stop_bad_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign par_calc_c = (^shift_q) ^ rxs;

  // Next-state and datapath decode; everything holds on cycles without a tick.
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bc_d       = bc_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    done_c     = 1'b0;
    stop_bad_c = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && !rxs) begin
            state_d = S_START;
            sc_d    = '0;
          end
        end
        S_START: begin
          if (sc_q == SC_HALF) begin
            sc_d = '0;
            if (!rxs) begin
              state_d   = S_DATA;
              bc_d      = '0;
              par_err_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_DATA: begin
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bc_d    = bc_q + 1'b1;
            if (bc_q == BC_LAST) begin
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_PAR: begin
          if (sc_q == SC_LAST) begin
            sc_d      = '0;
            par_err_d = (PARITY == 2) ? ~par_calc_c : par_calc_c;
            state_d   = S_STOP;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_STOP: begin
          // Leave at mid-stop so the next start edge is caught on time.
          if (sc_q == SC_LAST) begin
            sc_d       = '0;
            state_d    = S_IDLE;
            done_c     = 1'b1;
            stop_bad_c = !rxs;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          sc_d    = '0;
        end
      endcase
    end
  end

  // FSM state, counters, shift register and start-arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sc_q      <= '0;
      bc_q      <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      bc_q      <= bc_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      if (stop_bad_c) begin
        armed_q <= 1'b0;
      end else if (ena && rxs) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign state_out = state_q;

  // Output register: a completion may replace a word consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (valid_out && ready_in) begin
        overrun <= 1'b0;
      end
      if (done_c) begin
        if (!valid_out || ready_in) begin
          data_out   <= shift_q;
          frame_err  <= stop_bad_c;
          parity_err <= par_err_q;
          valid_out  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: four instances cover no/even/odd parity and
// a 9-bit, 16x, tick-gated configuration.
module tb_uart_rx_core;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rxl   = 4'hF;
  logic [3:0] rdy   = 4'b0110;
  logic [3:0] v;
  logic [3:0] fe;
  logic [3:0] pe;
  logic [3:0] ov;
  logic [6:0] d0, d1, d2;
  logic [8:0] d3;
  logic [2:0] st0, st1, st2, st3;
  logic [1:0] ecnt = 2'd0;
  logic       en3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_fall  = 0;
  int n_acc   [4] = '{default: 0};
  int n_start [4] = '{default: 0};
  int t_rise  [4] = '{default: 0};
  logic [3:0]  v_prev = 4'h0;
  logic [12:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ecnt <= ecnt + 2'd1;
  assign en3 = (ecnt == 2'd0);

  uart_rx_core #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .rx(rxl[0]), .ready_in(rdy[0]),
    .data_out(d0), .valid_out(v[0]), .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun(ov[0]), .state_out(st0));
  uart_rx_core #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .rx(rxl[1]), .ready_in(rdy[1]),
    .data_out(d1), .valid_out(v[1]), .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun(ov[1]), .state_out(st1));
  uart_rx_core #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .rx(rxl[2]), .ready_in(rdy[2]),
    .data_out(d2), .valid_out(v[2]), .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun(ov[2]), .state_out(st2));
  uart_rx_core #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY(0)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(en3), .rx(rxl[3]), .ready_in(rdy[3]),
    .data_out(d3), .valid_out(v[3]), .frame_err(fe[3]), .parity_err(pe[3]),
    .overrun(ov[3]), .state_out(st3));

  function automatic logic [8:0] get_d(input int i);
    case (i)
      0:       return 9'(d0);
      1:       return 9'(d1);
      2:       return 9'(d2);
      default: return d3;
    endcase
  endfunction

  function automatic logic [2:0] get_st(input int i);
    case (i)
      0:       return st0;
      1:       return st1;
      2:       return st2;
      default: return st3;
    endcase
  endfunction

  // Expected word tag: {instance, frame_err, parity_err, data}.
  function automatic logic [12:0] ew(input int i, input logic f, input logic p, input logic [8:0] d);
    return {2'(i), f, p, d};
  endfunction

  // Serial frame, LSB first: start, data, optional parity, stop.
  function automatic logic [11:0] mk(input logic [8:0] d, input int db, input int pen,
                                     input logic p, input logic stop);
    logic [11:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int k = 0; k < db; k++) b[1+k] = d[k];
    if (pen != 0) b[1+db] = p;
    b[1+db+pen] = stop;
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [11:0] bits, input int n, input int bitclk);
    t_fall = cyc;
    for (int k = 0; k < n; k++) begin
      rxl[i] = bits[k];
      repeat (bitclk) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ready(input int i);
    rdy[i] = 1'b1;
    @(posedge clk);
    #1;
    rdy[i] = 1'b0;
  endtask

  // Monitor: every accepted word is matched against the scoreboard head.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (get_st(i) == 3'd1) n_start[i]++;
      if (v[i] && !v_prev[i]) t_rise[i] = cyc;
      if (v[i] && rdy[i]) begin
        n_acc[i]++;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("word", 32'({2'(i), fe[i], pe[i], get_d(i)}), 32'(sb.pop_front()));
      end
    end
    v_prev = v;
  end

  initial begin
    int s0;
    int tr;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid",  32'(v[i]), 0);
      chk("rst_fe",     32'(fe[i]), 0);
      chk("rst_pe",     32'(pe[i]), 0);
      chk("rst_ovr",    32'(ov[i]), 0);
      chk("rst_state",  32'(get_st(i)), 0);
      chk("rst_data",   32'(get_d(i)), 0);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Basic frame, held word, latency
    sb.push_back(ew(0, 1'b0, 1'b0, 9'h02B));
    send(0, mk(9'h02B, 7, 0, 1'b0, 1'b1), 9, 8);
    chk("latency", t_rise[0] - t_fall, 71);
    chk("basic_valid", 32'(v[0]), 1);
    chk("basic_data", 32'(d0), 32'h2B);
    repeat (20) @(posedge clk);
    #1;
    chk("held_valid", 32'(v[0]), 1);
    chk("held_data", 32'(d0), 32'h2B);
    pulse_ready(0);
    chk("accept_clears_valid", 32'(v[0]), 0);

    // Parity: even then odd
    sb.push_back(ew(1, 1'b0, 1'b1, 9'h02B));
    send(1, mk(9'h02B, 7, 1, 1'b1, 1'b1), 10, 8);
    sb.push_back(ew(1, 1'b0, 1'b0, 9'h02B));
    send(1, mk(9'h02B, 7, 1, 1'b0, 1'b1), 10, 8);
    sb.push_back(ew(2, 1'b0, 1'b0, 9'h02B));
    send(2, mk(9'h02B, 7, 1, 1'b1, 1'b1), 10, 8);
    sb.push_back(ew(2, 1'b0, 1'b1, 9'h015));
    send(2, mk(9'h015, 7, 1, 1'b1, 1'b1), 10, 8);

    // Frame error followed by a held-low line
    rdy[0] = 1'b1;
    sb.push_back(ew(0, 1'b1, 1'b0, 9'h015));
    send(0, mk(9'h015, 7, 0, 1'b0, 1'b0), 9, 8);
    repeat (40) @(posedge clk);
    #1;
    chk("break_idle", 32'(st0), 0);
    chk("break_words", n_acc[0], 2);
    rxl[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("break_release_words", n_acc[0], 2);

    // Short glitch: START entered then abandoned
    s0 = n_start[0];
    rxl[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxl[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_start_cycles", n_start[0] - s0, 4);
    chk("glitch_state", 32'(st0), 0);
    chk("glitch_valid", 32'(v[0]), 0);
    chk("glitch_words", n_acc[0], 2);

    // Overrun on back-to-back frames with a stalled output
    rdy[0] = 1'b0;
    sb.push_back(ew(0, 1'b0, 1'b0, 9'h001));
    send(0, mk(9'h001, 7, 0, 1'b0, 1'b1), 9, 8);
    send(0, mk(9'h002, 7, 0, 1'b0, 1'b1), 9, 8);
    chk("ovr_valid", 32'(v[0]), 1);
    chk("ovr_data", 32'(d0), 1);
    chk("ovr_flag", 32'(ov[0]), 1);
    pulse_ready(0);
    chk("ovr_clear", 32'(ov[0]), 0);
    chk("ovr_valid_drop", 32'(v[0]), 0);

    // Completion coincident with accept
    sb.push_back(ew(0, 1'b0, 1'b0, 9'h003));
    send(0, mk(9'h003, 7, 0, 1'b0, 1'b1), 9, 8);
    sb.push_back(ew(0, 1'b0, 1'b0, 9'h004));
    tr = t_rise[0];
    fork
      send(0, mk(9'h004, 7, 0, 1'b0, 1'b1), 9, 8);
      begin
        repeat (70) @(posedge clk);
        #1;
        pulse_ready(0);
      end
    join
    chk("coinc_valid", 32'(v[0]), 1);
    chk("coinc_no_gap", t_rise[0], tr);
    chk("coinc_data", 32'(d0), 4);
    chk("coinc_ovr", 32'(ov[0]), 0);
    pulse_ready(0);

    // 9-bit, 16x, gated ticks: reset mid-DATA, then a clean frame
    send(3, mk(9'h0F0, 9, 0, 1'b0, 1'b1), 11, 64);
    chk("w9_valid", 32'(v[3]), 1);
    chk("w9_data", 32'(d3), 32'h0F0);
    send(3, mk(9'h1A5, 9, 0, 1'b0, 1'b1), 4, 64);
    chk("mid_data_state", 32'(st3), 2);
    #2;
    rst_n  = 1'b0;
    rxl[3] = 1'b1;
    #1;
    chk("rst3_valid", 32'(v[3]), 0);
    chk("rst3_data", 32'(d3), 0);
    chk("rst3_fe", 32'(fe[3]), 0);
    chk("rst3_ovr", 32'(ov[3]), 0);
    chk("rst3_state", 32'(st3), 0);
    chk("rst0_data", 32'(d0), 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rdy[3] = 1'b1;
    sb.push_back(ew(3, 1'b0, 1'b0, 9'h1A5));
    send(3, mk(9'h1A5, 9, 0, 1'b0, 1'b1), 11, 64);
    repeat (10) @(posedge clk);
    #1;

    chk("words_inst0", n_acc[0], 5);
    chk("words_inst1", n_acc[1], 2);
    chk("words_inst2", n_acc[2], 2);
    chk("words_inst3", n_acc[3], 1);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
